// File: rtl/midori_sbox_share_driver.sv
// rtl/midori_sbox_share_driver.sv - masks a 64-bit state into 3 shares, streams it through the shared Midori64 S-box and recombines the result.
// Optional OUTPUT_SHARES_EN exports the unrecombined output shares.
module midori_sbox_share_driver #(
  parameter int NIBBLES  = 16,
  parameter int SBOX_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   state_in,
  input  logic [7:0]             rnd,
  output logic [3:0]             sb_in1,
  output logic [3:0]             sb_in2,
  output logic [3:0]             sb_in3,
  input  logic [3:0]             sb_out1,
  input  logic [3:0]             sb_out2,
  input  logic [3:0]             sb_out3,
`ifdef OUTPUT_SHARES_EN
  output logic [4*NIBBLES-1:0]   state_out_sh1,
  output logic [4*NIBBLES-1:0]   state_out_sh2,
  output logic [4*NIBBLES-1:0]   state_out_sh3,
`endif
  output logic [4*NIBBLES-1:0]   state_out,
  output logic                   busy,
  output logic                   done
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              st_q, st_d;
  logic [CW-1:0]       iss_q, iss_d;
  logic [CW-1:0]       col_q, col_d;
  logic [SBOX_LAT-1:0] vld_q, vld_d;
  logic [W-1:0]        hold_q, hold_d;
  logic [W-1:0]        state_out_q, state_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                issue, collect;
  logic [3:0]          x_k;

`ifdef OUTPUT_SHARES_EN
  logic [W-1:0] sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
  logic [W-1:0] out_sh1_q, out_sh1_d, out_sh2_q, out_sh2_d, out_sh3_q, out_sh3_d;
`else
  logic [W-1:0] shadow_q, shadow_d;
`endif

  // Each nibble is masked with the rnd present in its own issue cycle.
  always_comb begin
    issue   = (st_q == RUN);
    collect = vld_q[SBOX_LAT-1];
    x_k     = hold_q[iss_q*4 +: 4];
    if (issue) begin
      sb_in1 = x_k ^ rnd[3:0] ^ rnd[7:4];
      sb_in2 = rnd[3:0];
      sb_in3 = rnd[7:4];
    end else begin
      sb_in1 = 4'h0;
      sb_in2 = 4'h0;
      sb_in3 = 4'h0;
    end
  end

  always_comb begin
    st_d        = st_q;
    iss_d       = iss_q;
    col_d       = col_q;
    hold_d      = hold_q;
    state_out_d = state_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    vld_d       = SBOX_LAT'({vld_q, issue});
`ifdef OUTPUT_SHARES_EN
    sh1_d     = sh1_q;
    sh2_d     = sh2_q;
    sh3_d     = sh3_q;
    out_sh1_d = out_sh1_q;
    out_sh2_d = out_sh2_q;
    out_sh3_d = out_sh3_q;
`else
    shadow_d  = shadow_q;
`endif

    if (collect) begin
`ifdef OUTPUT_SHARES_EN
      sh1_d[col_q*4 +: 4] = sb_out1;
      sh2_d[col_q*4 +: 4] = sb_out2;
      sh3_d[col_q*4 +: 4] = sb_out3;
`else
      shadow_d[col_q*4 +: 4] = sb_out1 ^ sb_out2 ^ sb_out3;
`endif
      col_d = col_q + 1'b1;
    end

    case (st_q)
      IDLE: begin
        if (start) begin
          hold_d = state_in;
          iss_d  = '0;
          col_d  = '0;
          busy_d = 1'b1;
          st_d   = RUN;
        end
      end
      RUN: begin
        iss_d = iss_q + 1'b1;
        if (iss_q == LAST) st_d = FLUSH;
      end
      FLUSH: begin
        if (collect && (col_q == LAST)) st_d = DONE;
      end
      DONE: begin
`ifdef OUTPUT_SHARES_EN
        out_sh1_d   = sh1_q;
        out_sh2_d   = sh2_q;
        out_sh3_d   = sh3_q;
        state_out_d = sh1_q ^ sh2_q ^ sh3_q;
`else
        state_out_d = shadow_q;
`endif
        done_d = 1'b1;
        busy_d = 1'b0;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      iss_q       <= '0;
      col_q       <= '0;
      vld_q       <= '0;
      hold_q      <= '0;
      state_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef OUTPUT_SHARES_EN
      sh1_q       <= '0;
      sh2_q       <= '0;
      sh3_q       <= '0;
      out_sh1_q   <= '0;
      out_sh2_q   <= '0;
      out_sh3_q   <= '0;
`else
      shadow_q    <= '0;
`endif
    end else begin
      st_q        <= st_d;
      iss_q       <= iss_d;
      col_q       <= col_d;
      vld_q       <= vld_d;
      hold_q      <= hold_d;
      state_out_q <= state_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef OUTPUT_SHARES_EN
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      sh3_q       <= sh3_d;
      out_sh1_q   <= out_sh1_d;
      out_sh2_q   <= out_sh2_d;
      out_sh3_q   <= out_sh3_d;
`else
      shadow_q    <= shadow_d;
`endif
    end
  end

  assign state_out = state_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef OUTPUT_SHARES_EN
  assign state_out_sh1 = out_sh1_q;
  assign state_out_sh2 = out_sh2_q;
  assign state_out_sh3 = out_sh3_q;
`endif

endmodule
